// File: rtl/lsbuffer_section_ctrl.sv
// Ownership sequencer for a multi-section lane-switched buffer.
// Sections are handed to one producer and one consumer in strict ring order.
// Every hand-over (producer or consumer release) pulses that section's lane-switch request.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   prod_acq_req / prod_acq_gnt  producer acquire request (level) / grant pulse
//   prod_sec                     section held by the producer
//   prod_rel                     producer release pulse
//   cons_acq_req / cons_acq_gnt  consumer acquire request (level) / grant pulse
//   cons_sec                     section held by the consumer
//   cons_rel                     consumer release pulse
//   sw_req                       per-section lane-switch request pulses
//   n_full                       number of sections in FULL or CONS state
//   ready                        high once the post-reset quiet period has elapsed
//   err                          sticky flag for a release while not holding
module lsbuffer_section_ctrl #(
    parameter int unsigned N_SECTIONS  = 2,
    parameter int unsigned SEC_W       = $clog2(N_SECTIONS),
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prod_acq_req,
    output logic                  prod_acq_gnt,
    output logic [SEC_W-1:0]      prod_sec,
    input  logic                  prod_rel,
    input  logic                  cons_acq_req,
    output logic                  cons_acq_gnt,
    output logic [SEC_W-1:0]      cons_sec,
    input  logic                  cons_rel,
    output logic [N_SECTIONS-1:0] sw_req,
    output logic [SEC_W:0]        n_full,
    output logic                  ready,
    output logic                  err
);

    localparam int unsigned CNT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned FULL_W = SEC_W + 1;

    typedef enum logic [1:0] {
        SEC_FREE = 2'd0,
        SEC_PROD = 2'd1,
        SEC_FULL = 2'd2,
        SEC_CONS = 2'd3
    } sec_state_e;

    sec_state_e                sec_q [N_SECTIONS];
    sec_state_e                sec_d [N_SECTIONS];
    logic [SEC_W-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [SEC_W-1:0]          prod_sec_q, prod_sec_d, cons_sec_q, cons_sec_d;
    logic                      prod_hold_q, prod_hold_d, cons_hold_q, cons_hold_d;
    logic                      prod_gnt_q, prod_gnt_d, cons_gnt_q, cons_gnt_d;
    logic [N_SECTIONS-1:0]     sw_req_q, sw_req_d;
    logic [FULL_W-1:0]         n_full_q, n_full_d;
    logic [CNT_W-1:0]          init_cnt_q, init_cnt_d;
    logic                      ready_q, ready_d, err_q, err_d;
    logic                      full_inc, full_dec;

    // Ring-pointer increment that also wraps for non-power-of-2 section counts.
    function automatic logic [SEC_W-1:0] ptr_inc(input logic [SEC_W-1:0] p);
        return (p == SEC_W'(N_SECTIONS - 1)) ? '0 : p + SEC_W'(1);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(N_SECTIONS); i++) sec_q[i] <= SEC_FREE;
            wr_q        <= '0;
            rd_q        <= '0;
            prod_sec_q  <= '0;
            cons_sec_q  <= '0;
            prod_hold_q <= 1'b0;
            cons_hold_q <= 1'b0;
            prod_gnt_q  <= 1'b0;
            cons_gnt_q  <= 1'b0;
            sw_req_q    <= '0;
            n_full_q    <= '0;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            prod_sec_q  <= prod_sec_d;
            cons_sec_q  <= cons_sec_d;
            prod_hold_q <= prod_hold_d;
            cons_hold_q <= cons_hold_d;
            prod_gnt_q  <= prod_gnt_d;
            cons_gnt_q  <= cons_gnt_d;
            sw_req_q    <= sw_req_d;
            n_full_q    <= n_full_d;
            init_cnt_q  <= init_cnt_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    // Next-state: grant eligibility reads registered state only, so a section
    // released this cycle cannot be re-granted until its switch pulse has gone out.
    always_comb begin
        sec_d       = sec_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        prod_sec_d  = prod_sec_q;
        cons_sec_d  = cons_sec_q;
        prod_hold_d = prod_hold_q;
        cons_hold_d = cons_hold_q;
        prod_gnt_d  = 1'b0;
        cons_gnt_d  = 1'b0;
        sw_req_d    = '0;
        err_d       = err_q;
        full_inc    = 1'b0;
        full_dec    = 1'b0;
        init_cnt_d  = init_cnt_q;
        ready_d     = ready_q;

        // Init counter saturates at its terminal value; ready follows one cycle later.
        if (init_cnt_q != CNT_W'(INIT_CYCLES - 1)) init_cnt_d = init_cnt_q + CNT_W'(1);
        else                                       ready_d    = 1'b1;

        // Producer release: FULL the section and point at the next one.
        if (prod_rel) begin
            if (prod_hold_q) begin
                sec_d[prod_sec_q]    = SEC_FULL;
                sw_req_d[prod_sec_q] = 1'b1;
                wr_d                 = ptr_inc(wr_q);
                prod_hold_d          = 1'b0;
                full_inc             = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // Consumer release: return the section to FREE.
        if (cons_rel) begin
            if (cons_hold_q) begin
                sec_d[cons_sec_q]    = SEC_FREE;
                sw_req_d[cons_sec_q] = 1'b1;
                rd_d                 = ptr_inc(rd_q);
                cons_hold_d          = 1'b0;
                full_dec             = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // Producer grant (never coincides with a valid producer release).
        if (ready_q && !prod_hold_q && prod_acq_req && sec_q[wr_q] == SEC_FREE) begin
            sec_d[wr_q] = SEC_PROD;
            prod_sec_d  = wr_q;
            prod_hold_d = 1'b1;
            prod_gnt_d  = 1'b1;
        end

        // Consumer grant.
        if (ready_q && !cons_hold_q && cons_acq_req && sec_q[rd_q] == SEC_FULL) begin
            sec_d[rd_q] = SEC_CONS;
            cons_sec_d  = rd_q;
            cons_hold_d = 1'b1;
            cons_gnt_d  = 1'b1;
        end

        case ({full_inc, full_dec})
            2'b10:   n_full_d = n_full_q + FULL_W'(1);
            2'b01:   n_full_d = n_full_q - FULL_W'(1);
            default: n_full_d = n_full_q;
        endcase
    end

    assign prod_acq_gnt = prod_gnt_q;
    assign cons_acq_gnt = cons_gnt_q;
    assign prod_sec     = prod_sec_q;
    assign cons_sec     = cons_sec_q;
    assign sw_req       = sw_req_q;
    assign n_full       = n_full_q;
    assign ready        = ready_q;
    assign err          = err_q;

endmodule

// File: tb/tb_lsbuffer_section_ctrl.sv
// Self-checking bench for lsbuffer_section_ctrl: directed hand-over scenarios
// followed by randomized traffic, all checked against a section-ownership model.
module tb_lsbuffer_section_ctrl;

    localparam int unsigned N    = 2;
    localparam int unsigned SW   = 1;
    localparam int unsigned INIT = 4;

    localparam int S_FREE = 0;
    localparam int S_PROD = 1;
    localparam int S_FULL = 2;
    localparam int S_CONS = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prod_acq_req = 1'b0, prod_rel = 1'b0;
    logic          cons_acq_req = 1'b0, cons_rel = 1'b0;
    logic          prod_acq_gnt, cons_acq_gnt, ready, err;
    logic [SW-1:0] prod_sec, cons_sec;
    logic [N-1:0]  sw_req;
    logic [SW:0]   n_full;

    int total = 0;
    int bad   = 0;

    // Reference model: section ownership as plain integers.
    int m_st [N];
    int m_wr, m_rd, m_psec, m_csec, m_cnt, m_sw;
    bit m_ph, m_ch, m_err, m_pg, m_cg;

    always #5 clk = ~clk;

    lsbuffer_section_ctrl #(.N_SECTIONS(N), .SEC_W(SW), .INIT_CYCLES(INIT)) dut (
        .clk(clk), .reset(reset),
        .prod_acq_req(prod_acq_req), .prod_acq_gnt(prod_acq_gnt), .prod_sec(prod_sec),
        .prod_rel(prod_rel),
        .cons_acq_req(cons_acq_req), .cons_acq_gnt(cons_acq_gnt), .cons_sec(cons_sec),
        .cons_rel(cons_rel),
        .sw_req(sw_req), .n_full(n_full), .ready(ready), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge of the ownership rules to the model.
    task automatic model_edge();
        bit rdy, pg, cg;
        if (reset) begin
            for (int i = 0; i < int'(N); i++) m_st[i] = S_FREE;
            m_wr = 0; m_rd = 0; m_psec = 0; m_csec = 0; m_cnt = 0; m_sw = 0;
            m_ph = 0; m_ch = 0; m_err = 0; m_pg = 0; m_cg = 0;
        end else begin
            rdy = (m_cnt >= int'(INIT));
            pg  = rdy && !m_ph && prod_acq_req && (m_st[m_wr] == S_FREE);
            cg  = rdy && !m_ch && cons_acq_req && (m_st[m_rd] == S_FULL);
            m_sw = 0;
            if (prod_rel) begin
                if (m_ph) begin
                    m_st[m_psec] = S_FULL;
                    m_sw |= (1 << m_psec);
                    m_wr = (m_wr + 1) % int'(N);
                    m_ph = 0;
                end else m_err = 1;
            end
            if (cons_rel) begin
                if (m_ch) begin
                    m_st[m_csec] = S_FREE;
                    m_sw |= (1 << m_csec);
                    m_rd = (m_rd + 1) % int'(N);
                    m_ch = 0;
                end else m_err = 1;
            end
            if (pg) begin m_st[m_wr] = S_PROD; m_psec = m_wr; m_ph = 1; end
            if (cg) begin m_st[m_rd] = S_CONS; m_csec = m_rd; m_ch = 1; end
            m_pg = pg;
            m_cg = cg;
            if (m_cnt < int'(INIT)) m_cnt++;
        end
    endtask

    task automatic check_all();
        int nf;
        nf = 0;
        for (int i = 0; i < int'(N); i++) if (m_st[i] == S_FULL || m_st[i] == S_CONS) nf++;
        check("prod_acq_gnt", 32'(prod_acq_gnt), 32'(m_pg));
        check("cons_acq_gnt", 32'(cons_acq_gnt), 32'(m_cg));
        check("prod_sec",     32'(prod_sec),     32'(m_psec));
        check("cons_sec",     32'(cons_sec),     32'(m_csec));
        check("sw_req",       32'(sw_req),       32'(m_sw));
        check("n_full",       32'(n_full),       32'(nf));
        check("ready",        32'(ready),        32'(m_cnt >= int'(INIT)));
        check("err",          32'(err),          32'(m_err));
    endtask

    // One cycle: drive inputs, clock, update model, sample #1 after the edge.
    task automatic step(input bit r, input bit pr, input bit prl, input bit cr, input bit crl);
        reset = r; prod_acq_req = pr; prod_rel = prl; cons_acq_req = cr; cons_rel = crl;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        bit r, pr, prl, cr, crl;

        // Reset, then producer requests through the quiet period.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            check("init_ready_low", 32'(ready), 32'd0);
            check("init_no_gnt", 32'(prod_acq_gnt), 32'd0);
        end
        step(0, 1, 0, 0, 0);
        check("ready_rise", 32'(ready), 32'd1);
        step(0, 1, 0, 0, 0);
        check("first_gnt", 32'(prod_acq_gnt), 32'd1);
        check("first_sec", 32'(prod_sec), 32'd0);
        step(0, 1, 0, 0, 0);
        check("gnt_one_cycle", 32'(prod_acq_gnt), 32'd0);

        // Release sec0 with consumer waiting.
        step(0, 0, 1, 1, 0);
        check("rel_sw01", 32'(sw_req), 32'd1);
        check("rel_nfull", 32'(n_full), 32'd1);
        check("cons_not_yet", 32'(cons_acq_gnt), 32'd0);
        step(0, 0, 0, 1, 0);
        check("cons_gnt", 32'(cons_acq_gnt), 32'd1);
        check("cons_sec0", 32'(cons_sec), 32'd0);
        check("sw_single", 32'(sw_req), 32'd0);

        // Producer fills sec1; sec0 still consumed, so producer stalls.
        step(0, 1, 0, 0, 0);
        check("prod_gnt_sec1", 32'(prod_sec), 32'd1);
        step(0, 0, 1, 0, 0);
        check("rel_sw10", 32'(sw_req), 32'd2);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("full_stall", 32'(prod_acq_gnt), 32'd0);
        check("full_nfull", 32'(n_full), 32'd2);
        step(0, 1, 0, 0, 1);
        check("crel_sw01", 32'(sw_req), 32'd1);
        check("no_gnt_same_edge", 32'(prod_acq_gnt), 32'd0);
        step(0, 1, 0, 0, 0);
        check("wrap_gnt", 32'(prod_acq_gnt), 32'd1);
        check("wrap_sec0", 32'(prod_sec), 32'd0);

        // Consumer takes sec1, then simultaneous releases.
        step(0, 0, 0, 1, 0);
        check("cons_sec1", 32'(cons_sec), 32'd1);
        step(0, 0, 1, 0, 1);
        check("dual_sw11", 32'(sw_req), 32'd3);
        check("dual_nfull", 32'(n_full), 32'd1);

        // Release while not holding.
        step(0, 0, 0, 0, 1);
        check("err_set", 32'(err), 32'd1);
        check("err_no_sw", 32'(sw_req), 32'd0);
        step(0, 0, 0, 0, 0);
        check("err_sticky", 32'(err), 32'd1);

        // Reset while the producer holds sec1.
        step(0, 1, 0, 0, 0);
        check("hold_sec1", 32'(prod_sec), 32'd1);
        step(1, 1, 0, 0, 0);
        check("rst_sw", 32'(sw_req), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_nfull", 32'(n_full), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        check("rst_no_early_gnt", 32'(prod_acq_gnt), 32'd0);
        step(0, 1, 0, 0, 0);
        check("rst_regnt", 32'(prod_acq_gnt), 32'd1);
        check("rst_regnt_sec", 32'(prod_sec), 32'd0);

        // Randomized traffic with occasional resets and stray releases.
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 299) == 0);
            pr  = ($urandom_range(0, 1) == 1);
            cr  = ($urandom_range(0, 1) == 1);
            prl = m_ph ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 599) == 0);
            crl = m_ch ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 599) == 0);
            step(r, pr, prl, cr, crl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
